// File: rtl/bp_be_pkg.sv
// Shared types for the backend page-table-walk request scheduler.
package bp_be_pkg;

   typedef enum logic [1:0] {
      e_walk_instr = 2'd0,
      e_walk_load  = 2'd1,
      e_walk_store = 2'd2
   } bp_be_walk_type_e;

   typedef enum logic [1:0] {
      e_sched_idle  = 2'd0,
      e_sched_issue = 2'd1,
      e_sched_wait  = 2'd2,
      e_sched_drain = 2'd3
   } bp_be_ptw_sched_state_e;

endpackage

// File: rtl/bp_be_ptw_req_slot.sv
// One pending TLB-miss holding slot: valid bit plus the walk type and vaddr it captured.
module bp_be_ptw_req_slot
   import bp_be_pkg::*;
#(
   parameter int vaddr_width_p = 39
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     capture_v_i,
   input  bp_be_walk_type_e         capture_type_i,
   input  logic [vaddr_width_p-1:0] capture_vaddr_i,
   input  logic                     clear_i,
   input  logic                     flush_i,
   output logic                     v_o,
   output bp_be_walk_type_e         type_o,
   output logic [vaddr_width_p-1:0] vaddr_o
);

   // An occupied slot ignores new misses; flush also drops a miss arriving that cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_o     <= 1'b0;
         type_o  <= e_walk_instr;
         vaddr_o <= '0;
      end else if (flush_i | clear_i) begin
         v_o <= 1'b0;
      end else if (capture_v_i & ~v_o) begin
         v_o     <= 1'b1;
         type_o  <= capture_type_i;
         vaddr_o <= capture_vaddr_i;
      end
   end

endmodule

// File: rtl/bp_be_ptw_req_sched.sv
// Arbitrates ITLB/DTLB misses onto the single PTW, one walk in flight, with flush drain
// and a per-walk watchdog.
module bp_be_ptw_req_sched
   import bp_be_pkg::*;
#(
   parameter int vaddr_width_p    = 39,
   parameter int timeout_cycles_p = 1023
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     imiss_v_i,
   input  logic [vaddr_width_p-1:0] imiss_vaddr_i,
   input  logic                     dmiss_v_i,
   input  logic                     dmiss_store_i,
   input  logic [vaddr_width_p-1:0] dmiss_vaddr_i,
   output logic                     ipend_o,
   output logic                     dpend_o,
   input  logic                     flush_i,
   output logic                     walk_v_o,
   output logic [1:0]               walk_type_o,
   output logic [vaddr_width_p-1:0] walk_vaddr_o,
   input  logic                     walk_ready_i,
   input  logic                     fill_v_i,
   input  logic                     fill_fault_i,
   output logic                     ifill_v_o,
   output logic                     dfill_v_o,
   output logic                     fault_o,
   output logic                     busy_o,
   output logic                     timeout_o
);

   localparam int cnt_width_lp = $clog2(timeout_cycles_p+1);
   localparam logic [cnt_width_lp-1:0] timeout_lp = cnt_width_lp'(timeout_cycles_p);

   bp_be_ptw_sched_state_e state_r, state_n;
   logic                     rr_r, gnt_r;  // 0 = instr, 1 = data
   logic [cnt_width_lp-1:0]  cnt_r;
   logic                     iclear, dclear;
   bp_be_walk_type_e         itype, dtype;
   logic [vaddr_width_p-1:0] ivaddr, dvaddr;

   bp_be_ptw_req_slot #(.vaddr_width_p(vaddr_width_p)) islot (
      .clk_i(clk_i), .reset_i(reset_i),
      .capture_v_i(imiss_v_i), .capture_type_i(e_walk_instr), .capture_vaddr_i(imiss_vaddr_i),
      .clear_i(iclear), .flush_i(flush_i),
      .v_o(ipend_o), .type_o(itype), .vaddr_o(ivaddr)
   );

   bp_be_ptw_req_slot #(.vaddr_width_p(vaddr_width_p)) dslot (
      .clk_i(clk_i), .reset_i(reset_i),
      .capture_v_i(dmiss_v_i), .capture_type_i(dmiss_store_i ? e_walk_store : e_walk_load),
      .capture_vaddr_i(dmiss_vaddr_i),
      .clear_i(dclear), .flush_i(flush_i),
      .v_o(dpend_o), .type_o(dtype), .vaddr_o(dvaddr)
   );

   // A miss arriving this cycle counts as pending so IDLE can issue it one cycle later.
   wire ireq     = ipend_o | imiss_v_i;
   wire dreq     = dpend_o | dmiss_v_i;
   wire hs       = (state_r == e_sched_issue) & walk_ready_i;
   wire inflight = (state_r == e_sched_wait) | (state_r == e_sched_drain);
   wire expire   = inflight & (cnt_r == timeout_lp) & ~fill_v_i;
   wire fill_ok  = (state_r == e_sched_wait) & fill_v_i & ~flush_i;
   wire done     = (state_r == e_sched_wait) & (fill_v_i | expire);

   assign iclear       = done & ~gnt_r;
   assign dclear       = done &  gnt_r;
   assign walk_v_o     = (state_r == e_sched_issue);
   assign walk_type_o  = gnt_r ? dtype : itype;
   assign walk_vaddr_o = gnt_r ? dvaddr : ivaddr;
   assign busy_o       = (state_r != e_sched_idle);
   assign timeout_o    = expire;

   always_comb begin
      state_n = state_r;
      case (state_r)
         e_sched_idle:  if (~flush_i & (ireq | dreq)) state_n = e_sched_issue;
         e_sched_issue: if (hs) state_n = flush_i ? e_sched_drain : e_sched_wait;
                        else if (flush_i) state_n = e_sched_idle;
         e_sched_wait:  if (fill_v_i | expire) state_n = e_sched_idle;
                        else if (flush_i) state_n = e_sched_drain;
         e_sched_drain: if (fill_v_i | expire) state_n = e_sched_idle;
         default:       state_n = e_sched_idle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r   <= e_sched_idle;
         rr_r      <= 1'b0;
         gnt_r     <= 1'b0;
         cnt_r     <= '0;
         ifill_v_o <= 1'b0;
         dfill_v_o <= 1'b0;
         fault_o   <= 1'b0;
      end else begin
         state_r   <= state_n;
         ifill_v_o <= fill_ok & ~gnt_r;
         dfill_v_o <= fill_ok &  gnt_r;
         fault_o   <= fill_ok & fill_fault_i;
         if ((state_r == e_sched_idle) & (state_n == e_sched_issue)) begin
            gnt_r <= (ireq & dreq) ? rr_r : dreq;
            if (ireq & dreq) rr_r <= ~rr_r;
         end
         if (hs) cnt_r <= '0;
         else if (inflight) cnt_r <= cnt_r + cnt_width_lp'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) assert (!fill_v_i || inflight);
   end

   assert property (@(posedge clk_i) disable iff (reset_i)
      (walk_v_o && !walk_ready_i && !flush_i) |=> walk_v_o);

endmodule

// File: tb/tb_bp_be_ptw_req_sched.sv
// Directed scenarios followed by random traffic, all compared against a transaction-level model.
module tb_bp_be_ptw_req_sched;
   localparam int VW = 39;
   localparam int T  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          imiss_v_i, dmiss_v_i, dmiss_store_i, flush_i, walk_ready_i, fill_v_i, fill_fault_i;
   logic [VW-1:0] imiss_vaddr_i, dmiss_vaddr_i, walk_vaddr_o;
   logic          ipend_o, dpend_o, walk_v_o, ifill_v_o, dfill_v_o, fault_o, busy_o, timeout_o;
   logic [1:0]    walk_type_o;

   bp_be_ptw_req_sched #(.vaddr_width_p(VW), .timeout_cycles_p(T)) dut (
      .clk_i(clk), .reset_i(rst),
      .imiss_v_i(imiss_v_i), .imiss_vaddr_i(imiss_vaddr_i),
      .dmiss_v_i(dmiss_v_i), .dmiss_store_i(dmiss_store_i), .dmiss_vaddr_i(dmiss_vaddr_i),
      .ipend_o(ipend_o), .dpend_o(dpend_o), .flush_i(flush_i),
      .walk_v_o(walk_v_o), .walk_type_o(walk_type_o), .walk_vaddr_o(walk_vaddr_o),
      .walk_ready_i(walk_ready_i), .fill_v_i(fill_v_i), .fill_fault_i(fill_fault_i),
      .ifill_v_o(ifill_v_o), .dfill_v_o(dfill_v_o), .fault_o(fault_o),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   int checks = 0;
   int errors = 0;

   // Model: two miss records, the walk phase (0 none, 1 offered, 2 accepted, 3 orphaned by flush),
   // which source owns the walk, cycles since acceptance, and the round-robin preference.
   bit          m_iv, m_dv, m_dst, m_rr, m_if, m_df, m_flt;
   logic [VW-1:0] m_ia, m_da;
   int          m_ph, m_who, m_age;

   task automatic model_reset();
      m_iv = 0; m_dv = 0; m_dst = 0; m_rr = 0; m_if = 0; m_df = 0; m_flt = 0;
      m_ia = '0; m_da = '0; m_ph = 0; m_who = 0; m_age = 0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit im = 0, input logic [VW-1:0] ia = '0, input bit dm = 0,
                        input bit ds = 0, input logic [VW-1:0] da = '0, input bit fl = 0,
                        input bit rdy = 0, input bit fv = 0, input bit ff = 0);
      @(negedge clk);
      imiss_v_i = im; imiss_vaddr_i = ia; dmiss_v_i = dm; dmiss_store_i = ds; dmiss_vaddr_i = da;
      flush_i = fl; walk_ready_i = rdy; fill_v_i = fv; fill_fault_i = ff;
      #1;
      chk("ipend", ipend_o, m_iv);
      chk("dpend", dpend_o, m_dv);
      chk("walk_v", walk_v_o, m_ph == 1);
      chk("busy", busy_o, m_ph != 0);
      chk("ifill", ifill_v_o, m_if);
      chk("dfill", dfill_v_o, m_df);
      chk("fault", fault_o, m_flt);
      chk("timeout", timeout_o, (m_ph >= 2) && (m_age == T) && !fv);
      if (m_ph == 1) begin
         chk("walk_type", walk_type_o, m_who == 0 ? 0 : (m_dst ? 2 : 1));
         chk("walk_vaddr", walk_vaddr_o, m_who == 0 ? m_ia : m_da);
      end
   endtask

   task automatic tick();
      bit oiv, odv, ireq, dreq;
      @(posedge clk);
      if (rst) begin model_reset(); return; end
      oiv = m_iv; odv = m_dv;
      m_if = 0; m_df = 0; m_flt = 0;
      case (m_ph)
         0: begin
            ireq = oiv | imiss_v_i; dreq = odv | dmiss_v_i;
            if (!flush_i && (ireq || dreq)) begin
               m_who = (ireq && dreq) ? int'(m_rr) : int'(dreq);
               if (ireq && dreq) m_rr = !m_rr;
               m_ph = 1;
            end
         end
         1: begin
            if (walk_ready_i) begin m_age = 0; m_ph = flush_i ? 3 : 2; end
            else if (flush_i) m_ph = 0;
         end
         2: begin
            if (fill_v_i) begin
               if (!flush_i) begin
                  if (m_who == 1) begin m_df = 1; m_dv = 0; end
                  else begin m_if = 1; m_iv = 0; end
                  m_flt = fill_fault_i;
               end
               m_ph = 0;
            end else if (m_age == T) begin
               if (m_who == 1) m_dv = 0; else m_iv = 0;
               m_ph = 0;
            end else if (flush_i) m_ph = 3;
            m_age++;
         end
         default: begin
            if (fill_v_i || m_age == T) m_ph = 0;
            m_age++;
         end
      endcase
      if (flush_i) begin m_iv = 0; m_dv = 0; end
      else begin
         if (imiss_v_i && !oiv) begin m_iv = 1; m_ia = imiss_vaddr_i; end
         if (dmiss_v_i && !odv) begin m_dv = 1; m_da = dmiss_vaddr_i; m_dst = dmiss_store_i; end
      end
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      drive(); chk("rst_busy", busy_o, 0); chk("rst_walk", walk_v_o, 0); tick();
      drive(); tick();
      @(negedge clk); rst = 1'b0;
      drive(); tick(); drive(); tick();

      // Single instruction walk: issue one cycle after the miss, fill routed one cycle later.
      drive(.im(1), .ia(39'h0_8000_1000), .rdy(1)); tick();
      drive(.rdy(1)); chk("t1_walk_v", walk_v_o, 1); chk("t1_type", walk_type_o, 0);
      chk("t1_vaddr", walk_vaddr_o, 39'h0_8000_1000); tick();
      repeat (3) begin drive(); tick(); end
      drive(.fv(1)); tick();
      drive(); chk("t1_ifill", ifill_v_o, 1); chk("t1_ipend", ipend_o, 0); tick();

      // Simultaneous misses: instr wins first, store follows; next contest favours data.
      drive(.im(1), .ia(39'h1000), .dm(1), .ds(1), .da(39'h2000)); tick();
      drive(.rdy(1)); chk("t2_first", walk_type_o, 0); tick();
      drive(); tick();
      drive(.fv(1)); tick();
      drive(); chk("t2_ifill", ifill_v_o, 1); chk("t2_dpend", dpend_o, 1); tick();
      drive(.rdy(1)); chk("t2_second", walk_type_o, 2); chk("t2_vaddr", walk_vaddr_o, 39'h2000); tick();
      drive(.fv(1)); tick();
      drive(); chk("t2_dfill", dfill_v_o, 1); tick();
      drive(.im(1), .ia(39'h3000), .dm(1), .ds(0), .da(39'h4000)); tick();
      drive(.rdy(1)); chk("t2_rr_data", walk_type_o, 1); tick();
      drive(.fv(1)); tick();
      drive(); tick();
      drive(.rdy(1)); chk("t2_rr_instr", walk_type_o, 0); tick();
      drive(.fv(1)); tick();
      drive(); tick();

      // Flush while the walk is still being offered.
      drive(.dm(1), .da(39'h5000)); tick();
      drive(); tick();
      drive(); tick();
      drive(.fl(1)); chk("t3_walk_before", walk_v_o, 1); tick();
      drive(); chk("t3_withdrawn", walk_v_o, 0); chk("t3_dpend", dpend_o, 0); tick();
      drive(); chk("t3_no_dfill", dfill_v_o, 0); tick();

      // Flush during WAIT: the later fill is swallowed.
      drive(.im(1), .ia(39'h6000)); tick();
      drive(.rdy(1)); tick();
      drive(.fl(1)); tick();
      drive(); tick();
      drive(); tick();
      drive(.fv(1)); chk("t4_busy", busy_o, 1); tick();
      drive(); chk("t4_idle", busy_o, 0); chk("t4_no_ifill", ifill_v_o, 0); tick();

      // Watchdog with a data miss queued behind the stuck walk.
      drive(.im(1), .ia(39'h7000)); tick();
      drive(.rdy(1)); tick();
      for (int k = 0; k <= T; k++) begin
         drive(.dm(k == 0), .da(39'h9000));
         chk("t5_timeout", timeout_o, k == T);
         tick();
      end
      drive(); chk("t5_ipend", ipend_o, 0); chk("t5_dpend", dpend_o, 1); tick();
      drive(.rdy(1)); chk("t5_next_walk", walk_v_o, 1); chk("t5_next_type", walk_type_o, 1); tick();
      drive(.fv(1)); tick();
      drive(); tick();

      // Faulting load walk.
      drive(.dm(1), .da(39'ha000)); tick();
      drive(.rdy(1)); tick();
      drive(); tick();
      drive(.fv(1), .ff(1)); tick();
      drive(); chk("t6_dfill", dfill_v_o, 1); chk("t6_fault", fault_o, 1); chk("t6_ifill", ifill_v_o, 0); tick();

      // Asynchronous reset in the middle of a walk.
      drive(.im(1), .ia(39'hb000)); tick();
      drive(.rdy(1)); tick();
      drive();
      #1 rst = 1'b1;
      #1 chk("rst_async_busy", busy_o, 0); chk("rst_async_ipend", ipend_o, 0);
      tick();
      drive(); tick();
      @(negedge clk); rst = 1'b0;
      drive(); tick();

      // Random traffic; fills only while a walk is outstanding.
      for (int n = 0; n < 600; n++) begin
         drive(.im($urandom_range(4) == 0), .ia(VW'({$urandom(), $urandom()})),
               .dm($urandom_range(4) == 0), .ds($urandom_range(1) == 1),
               .da(VW'({$urandom(), $urandom()})), .fl($urandom_range(22) == 0),
               .rdy($urandom_range(1) == 1), .fv((m_ph >= 2) && ($urandom_range(5) == 0)),
               .ff($urandom_range(1) == 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
